// File: rtl/if_stage.sv
// Instruction-fetch stage (pre-IF + IF): issues SRAM reads, holds the fetched
// instruction across decode stalls and squashes wrong-path fetches on redirect.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h1c000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ds_allowin,
   input  logic [32:0] br_bus,
   output logic        fs_to_ds_valid,
   output logic [63:0] fs_to_ds_bus,
   output logic        inst_sram_en,
   output logic [3:0]  inst_sram_we,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic [31:0] inst_sram_rdata
);

   logic        br_taken;
   logic [31:0] br_target;
   logic        to_fs_valid;
   logic [31:0] seq_pc;
   logic [31:0] nextpc;
   logic        fs_valid;
   logic [31:0] fs_pc;
   logic        fs_ready_go;
   logic        fs_allowin;
   logic        buf_valid;
   logic [31:0] inst_buf;
   logic [31:0] fs_inst;

   assign br_taken  = br_bus[32];
   assign br_target = br_bus[31:0];

   assign to_fs_valid = ~reset;
   assign seq_pc      = fs_pc + 32'd4;
   assign nextpc      = br_taken ? br_target : seq_pc;

   // A redirect always opens the stage so the target is fetched immediately.
   assign fs_ready_go = 1'b1;
   assign fs_allowin  = ~fs_valid | (fs_ready_go & ds_allowin) | br_taken;

   assign inst_sram_en    = to_fs_valid & fs_allowin;
   assign inst_sram_we    = 4'h0;
   assign inst_sram_addr  = nextpc;
   assign inst_sram_wdata = 32'h0;

   assign fs_inst        = buf_valid ? inst_buf : inst_sram_rdata;
   assign fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken & ~reset;
   assign fs_to_ds_bus   = {fs_inst, fs_pc};

   always_ff @(posedge clk) begin
      if (reset) begin
         fs_valid <= 1'b0;
         fs_pc    <= RESET_PC - 32'd4;
      end else if (inst_sram_en) begin
         fs_valid <= 1'b1;
         fs_pc    <= nextpc;
      end
   end

   // SRAM output is only guaranteed the cycle after a read, so a stalled
   // instruction is latched here until the stage is refilled.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_valid <= 1'b0;
         inst_buf  <= 32'h0;
      end else if (inst_sram_en) begin
         buf_valid <= 1'b0;
      end else if (fs_valid & ~ds_allowin & ~buf_valid & ~br_taken) begin
         buf_valid <= 1'b1;
         inst_buf  <= inst_sram_rdata;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: stimulus pushes expected decode transfers into
// a queue, a negedge monitor pops and compares every handshake.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        ds_allowin;
   logic [32:0] br_bus;
   logic        fs_to_ds_valid;
   logic [63:0] fs_to_ds_bus;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_we;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;

   logic        corrupt;
   logic [31:0] sram_q = 32'h0;
   int          errors = 0;
   int          checks = 0;
   logic [63:0] expq[$];

   always #5 clk = ~clk;

   if_stage #(.RESET_PC(32'h1c000000)) dut (
      .clk             (clk),
      .reset           (reset),
      .ds_allowin      (ds_allowin),
      .br_bus          (br_bus),
      .fs_to_ds_valid  (fs_to_ds_valid),
      .fs_to_ds_bus    (fs_to_ds_bus),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_we    (inst_sram_we),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata),
      .inst_sram_rdata (inst_sram_rdata)
   );

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return a ^ 32'h5a5a5a5a;
   endfunction

   function automatic logic [63:0] busWord(input logic [31:0] pc);
      return {memWord(pc), pc};
   endfunction

   // 1-cycle synchronous SRAM; output holds when not enabled.
   always @(posedge clk) begin
      if (inst_sram_en)
         sram_q <= memWord(inst_sram_addr);
   end
   assign inst_sram_rdata = corrupt ? 32'hdeadbeef : sram_q;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic allow, input logic bt,
                                input logic [31:0] tgt, input logic bad);
      @(posedge clk);
      #1;
      reset      = rst;
      ds_allowin = allow;
      br_bus     = {bt, tgt};
      corrupt    = bad;
      @(negedge clk);
   endtask

   task automatic checkFetch(input string name, input logic en, input logic [31:0] addr, input logic vld);
      checkOutput({name, "_en"}, 64'(inst_sram_en), 64'(en));
      if (en)
         checkOutput({name, "_addr"}, 64'(inst_sram_addr), 64'(addr));
      checkOutput({name, "_valid"}, 64'(fs_to_ds_valid), 64'(vld));
   endtask

   // Scoreboard monitor: every decode handshake must match the next expected bus.
   always @(negedge clk) begin
      if (fs_to_ds_valid && ds_allowin) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_transfer: got %h expected none", fs_to_ds_bus);
         end else begin
            checkOutput("transfer", fs_to_ds_bus, expq.pop_front());
         end
      end
   end

   initial begin
      reset = 1'b1; ds_allowin = 1'b1; br_bus = 33'h0; corrupt = 1'b0;
      applyStimulus(1, 1, 0, 32'h0, 0);
      applyStimulus(1, 1, 0, 32'h0, 0);
      checkFetch("reset", 1'b0, 32'h0, 1'b0);

      // Straight-line fetch, then a reset while a valid instruction is held.
      expq.push_back(busWord(32'h1c000000));
      expq.push_back(busWord(32'h1c000004));
      expq.push_back(busWord(32'h1c000008));
      expq.push_back(busWord(32'h1c00000c));
      applyStimulus(0, 1, 0, 32'h0, 0); checkFetch("seq0", 1'b1, 32'h1c000000, 1'b0);
      applyStimulus(0, 1, 0, 32'h0, 0); checkFetch("seq1", 1'b1, 32'h1c000004, 1'b1);
      applyStimulus(0, 1, 0, 32'h0, 0); checkFetch("seq2", 1'b1, 32'h1c000008, 1'b1);
      applyStimulus(0, 1, 0, 32'h0, 0); checkFetch("seq3", 1'b1, 32'h1c00000c, 1'b1);
      applyStimulus(0, 1, 0, 32'h0, 0); checkFetch("seq4", 1'b1, 32'h1c000010, 1'b1);
      applyStimulus(1, 1, 0, 32'h0, 0); checkFetch("midrst", 1'b0, 32'h0, 1'b0);

      expq.push_back(busWord(32'h1c000000));
      expq.push_back(busWord(32'h1c000004));
      expq.push_back(busWord(32'h1c000100));
      expq.push_back(busWord(32'h1c000200));
      expq.push_back(busWord(32'h1c000204));
      expq.push_back(busWord(32'h1c000080));
      applyStimulus(0, 1, 0, 32'h0, 0); checkFetch("s2_c1", 1'b1, 32'h1c000000, 1'b0);
      applyStimulus(0, 1, 0, 32'h0, 0); checkFetch("s2_c2", 1'b1, 32'h1c000004, 1'b1);

      // Stall at pc 4 with SRAM output corrupted after the first stall cycle.
      applyStimulus(0, 0, 0, 32'h0, 0); checkFetch("stall1", 1'b0, 32'h0, 1'b1);
      checkOutput("stall1_bus", fs_to_ds_bus, busWord(32'h1c000004));
      applyStimulus(0, 0, 0, 32'h0, 1); checkFetch("stall2", 1'b0, 32'h0, 1'b1);
      checkOutput("stall2_bus", fs_to_ds_bus, busWord(32'h1c000004));
      applyStimulus(0, 0, 0, 32'h0, 1); checkFetch("stall3", 1'b0, 32'h0, 1'b1);
      checkOutput("stall3_bus", fs_to_ds_bus, busWord(32'h1c000004));
      applyStimulus(0, 1, 0, 32'h0, 1); checkFetch("release", 1'b1, 32'h1c000008, 1'b1);
      checkOutput("release_bus", fs_to_ds_bus, busWord(32'h1c000004));

      // Single-cycle redirect squashing pc 8.
      applyStimulus(0, 1, 1, 32'h1c000100, 0); checkFetch("br1", 1'b1, 32'h1c000100, 1'b0);
      applyStimulus(0, 1, 0, 32'h0, 0); checkFetch("br1_tgt", 1'b1, 32'h1c000104, 1'b1);

      // Redirect held three cycles while decode is stalled.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 1, 32'h1c000200, 0);
         checkFetch($sformatf("brhold%0d", i), 1'b1, 32'h1c000200, 1'b0);
      end
      applyStimulus(0, 1, 0, 32'h0, 0); checkFetch("brhold_tgt", 1'b1, 32'h1c000204, 1'b1);
      checkOutput("brhold_bus", fs_to_ds_bus, busWord(32'h1c000200));
      applyStimulus(0, 1, 0, 32'h0, 0); checkFetch("brhold_seq", 1'b1, 32'h1c000208, 1'b1);

      // Back-to-back redirects: only the second target is delivered.
      applyStimulus(0, 1, 1, 32'h1c000040, 0); checkFetch("b2b1", 1'b1, 32'h1c000040, 1'b0);
      applyStimulus(0, 1, 1, 32'h1c000080, 0); checkFetch("b2b2", 1'b1, 32'h1c000080, 1'b0);
      applyStimulus(0, 1, 0, 32'h0, 0); checkFetch("b2b_tgt", 1'b1, 32'h1c000084, 1'b1);

      // Reset while the buffer holds a stalled instruction.
      applyStimulus(0, 0, 0, 32'h0, 0); checkFetch("prerst", 1'b0, 32'h0, 1'b1);
      applyStimulus(1, 0, 0, 32'h0, 1); checkFetch("bufrst", 1'b0, 32'h0, 1'b0);
      expq.push_back(busWord(32'h1c000000));
      applyStimulus(0, 0, 0, 32'h0, 0); checkFetch("postrst", 1'b1, 32'h1c000000, 1'b0);
      checkOutput("postrst_buf", 64'(dut.buf_valid), 64'd0);
      applyStimulus(0, 1, 0, 32'h0, 0); checkFetch("postrst2", 1'b1, 32'h1c000004, 1'b1);
      applyStimulus(0, 0, 0, 32'h0, 0);

      checkOutput("queue_drained", 64'(expq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage (pre-IF plus IF) of the 5-stage LoongArch pipeline.
- Produces the {inst, pc} bus and valid consumed by the decode stage, and consumes the decode stage's branch bus {br_taken, br_target}.
- Drives the synchronous instruction SRAM, which has 1-cycle read latency.
- Holds a one-entry instruction buffer so fetched data survives decode back-pressure.
- Cancels the wrong-path instruction whenever decode redirects.

Parameters:
- RESET_PC, 32'h1c000000, address of the first fetch after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- ds_allowin  in  1  decode stage can accept a bus this cycle
- br_bus  in  33  {br_taken[32], br_target[31:0]} from decode
- fs_to_ds_valid  out  1  IF bus valid to decode
- fs_to_ds_bus  out  64  {fs_inst[63:32], fs_pc[31:0]}
- inst_sram_en  out  1  SRAM read request
- inst_sram_we  out  4  byte write enables; tied 4'h0
- inst_sram_addr  out  32  fetch address
- inst_sram_wdata  out  32  tied 32'h0
- inst_sram_rdata  in  32  SRAM data; valid the cycle after a request

Behaviour:
- Reset (synchronous, active-high): fs_valid=0, fs_pc=RESET_PC-4, buf_valid=0, buf=0.
  - While reset is high: fs_to_ds_valid=0, inst_sram_en=0.
- Pre-IF:
  - to_fs_valid = ~reset.
  - seq_pc = fs_pc + 4, 32-bit wrap-around ignored.
  - nextpc = br_taken ? br_target : seq_pc.
  - inst_sram_addr = nextpc.
  - inst_sram_en = to_fs_valid & fs_allowin.
- IF stage:
  - fs_ready_go = 1.
  - fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin) | br_taken.
  - On a cycle with inst_sram_en: fs_valid<=1, fs_pc<=nextpc. Otherwise fs_valid and fs_pc hold.
- Latency: a request issued in cycle N appears on fs_to_ds_bus in cycle N+1, with data taken directly from inst_sram_rdata.
- Instruction buffer:
  - fs_inst = buf_valid ? buf : inst_sram_rdata.
  - Capture: when fs_valid & ~ds_allowin & ~buf_valid & ~br_taken, set buf<=inst_sram_rdata and buf_valid<=1.
  - Clear: buf_valid<=0 when inst_sram_en is high, since fs is being refilled.
  - Capture and clear are mutually exclusive because en implies fs_allowin. Reset dominates both.
  - Reason: SRAM output may change once en is low or the address moves, so the buffer is mandatory.
- Output valid: fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken.
- Redirect (br_taken=1):
  - The instruction currently in IF is wrong-path: it is never presented to decode and its buffered copy is discarded.
  - The target is requested in the same cycle, independent of ds_allowin.
  - If br_taken stays high for several cycles (decode stalled holding a branch), the target is re-requested every cycle. fs_pc and fs_valid stay at the target, with no duplicate issue to decode.
  - The first cycle br_taken is low, the target instruction becomes presentable. It then follows the normal handshake.
- Handshake: a transfer occurs when fs_to_ds_valid & ds_allowin. If ds_allowin is low, fs_to_ds_bus stays stable (pc and inst) until transfer or redirect.
- Reset mid-operation: all in-flight fetch and buffer state is dropped. The first request after reset deasserts goes to RESET_PC.
- br_target alignment is not checked; the low 2 bits are passed through to the SRAM address.

Test Plan:
- Reset then release with ds_allowin=1 and SRAM returning mem[pc]:
  - First cycle: inst_sram_en=1, addr=0x1c000000.
  - Following cycles: fs_to_ds_bus pc = 0x1c000000, 0x1c000004, 0x1c000008; one instruction per cycle.
- ds_allowin=0 for 3 cycles while fs holds pc 0x1c000004, and SRAM rdata is corrupted to 0xdeadbeef after the first stall cycle:
  - inst_sram_en=0 throughout the stall.
  - The bus keeps the original instruction and pc 0x1c000004.
  - On release it transfers once, then fetches 0x1c000008.
- br_bus={1, 0x1c000100} for one cycle while fs_valid holds pc 0x1c000008:
  - fs_to_ds_valid=0 that cycle; addr=0x1c000100.
  - Next cycle the bus shows pc 0x1c000100; 0x1c000008 never reaches decode.
- br_taken held high 3 cycles with ds_allowin=0, target 0x1c000200:
  - addr=0x1c000200 each cycle; fs_to_ds_valid=0.
  - After br_taken drops, exactly one transfer of pc 0x1c000200, then 0x1c000204.
- Back-to-back redirects (targets 0x1c000040 then 0x1c000080 in consecutive cycles):
  - Only 0x1c000080 is delivered; 0x1c000040 is cancelled.
- Reset asserted while the buffer is valid and a stall is active:
  - Next cycle fs_to_ds_valid=0 and buf_valid=0.
  - After release, the first fetch is 0x1c000000.
